// File: rtl/avg_det_pkg.sv
// Shared types and constants for the averaged-sample threshold detector.
package avg_det_pkg;

  localparam int AVG_DET_WIDTH     = 8;
  localparam int AVG_DET_CNT_WIDTH = 8;
  localparam int PERSIST_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_BELOW   = 2'd0,
    ST_PEND_UP = 2'd1,
    ST_ABOVE   = 2'd2,
    ST_PEND_DN = 2'd3
  } det_state_e;

  // The level flag stays high while a fall is still pending.
  function automatic logic is_high_side(input det_state_e s);
    return (s == ST_ABOVE) || (s == ST_PEND_DN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clear takes effect first, then the increment, no wrap.
module sat_counter
  import avg_det_pkg::*;
#(
  parameter int CNT_WIDTH = AVG_DET_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic [CNT_WIDTH-1:0] base;

  always_comb begin
    base    = clr ? '0 : count_q;
    count_d = base;
    if (inc && (base != CNT_MAX)) begin
      count_d = base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/avg_threshold_detector.sv
// Hysteresis threshold detector with persistence filter, event pulses and a
// saturating rise counter. Define AVG_DET_PEAK_HOLD_EN to add the peak-hold output.
module avg_threshold_detector
  import avg_det_pkg::*;
#(
  parameter int WIDTH     = AVG_DET_WIDTH,
  parameter int PERSIST   = 3,
  parameter int CNT_WIDTH = AVG_DET_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [WIDTH-1:0]     sample,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     thr_hi,
  input  logic [WIDTH-1:0]     thr_lo,
  input  logic                 clear,
  output logic                 above,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
`ifdef AVG_DET_PEAK_HOLD_EN
  output logic [CNT_WIDTH-1:0] event_count,
  output logic [WIDTH-1:0]     peak
`else
  output logic [CNT_WIDTH-1:0] event_count
`endif
);

  // PERSIST is expected to lie in 1..15 so it fits the persistence counter.
  localparam logic [PERSIST_CNT_W-1:0] PERSIST_TGT = PERSIST_CNT_W'(PERSIST);

  det_state_e               state_q, state_d;
  logic [PERSIST_CNT_W-1:0] pcnt_q, pcnt_d;
  logic [PERSIST_CNT_W-1:0] pcnt_inc;
  logic                     above_q;
  logic                     rise_q, rise_d;
  logic                     fall_q, fall_d;
  logic                     accept;
  logic                     qual_hi, qual_lo;

  assign accept   = ena & sample_valid;
  assign qual_hi  = (sample >= thr_hi);
  assign qual_lo  = (sample <= thr_lo);
  assign pcnt_inc = pcnt_q + 1'b1;

  // The resting states hold pcnt at zero, so the resting and pending states
  // share one count-and-compare path; PERSIST=1 commits straight from rest.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (accept) begin
      case (state_q)
        ST_BELOW, ST_PEND_UP: begin
          if (qual_hi) begin
            if (pcnt_inc == PERSIST_TGT) begin
              state_d = ST_ABOVE;
              pcnt_d  = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = ST_PEND_UP;
              pcnt_d  = pcnt_inc;
            end
          end else begin
            state_d = ST_BELOW;
            pcnt_d  = '0;
          end
        end
        ST_ABOVE, ST_PEND_DN: begin
          if (qual_lo) begin
            if (pcnt_inc == PERSIST_TGT) begin
              state_d = ST_BELOW;
              pcnt_d  = '0;
              fall_d  = 1'b1;
            end else begin
              state_d = ST_PEND_DN;
              pcnt_d  = pcnt_inc;
            end
          end else begin
            state_d = ST_ABOVE;
            pcnt_d  = '0;
          end
        end
        default: begin
          state_d = ST_BELOW;
          pcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BELOW;
      pcnt_q  <= '0;
      above_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      above_q <= is_high_side(state_d);
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign above      = above_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_event_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (rise_d),
    .clr  (clear),
    .count(event_count)
  );

`ifdef AVG_DET_PEAK_HOLD_EN
  logic [WIDTH-1:0] peak_q, peak_d;

  // Clear resets the running max before the same-cycle sample is considered.
  always_comb begin
    peak_d = clear ? '0 : peak_q;
    if (accept && (sample > peak_d)) begin
      peak_d = sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Directed bench: vector table for the basic sequences, hand sequences for
// async reset, saturation (second instance with CNT_WIDTH=2), clear and peak.
`timescale 1ns/1ps
module tb_avg_threshold_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] sample;
  logic       sample_valid;
  logic [7:0] thr_hi;
  logic [7:0] thr_lo;
  logic       clear;

  logic       above8, rise8, fall8;
  logic [7:0] cnt8;
  logic       above2, rise2, fall2;
  logic [1:0] cnt2;
`ifdef AVG_DET_PEAK_HOLD_EN
  logic [7:0] peak8, peak2;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int e8 = 0;
  int e2 = 0;

  always #5 clk = ~clk;

  avg_threshold_detector #(.WIDTH(8), .PERSIST(3), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample(sample),
    .sample_valid(sample_valid), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .clear(clear), .above(above8), .rise_pulse(rise8), .fall_pulse(fall8),
`ifdef AVG_DET_PEAK_HOLD_EN
    .event_count(cnt8), .peak(peak8)
`else
    .event_count(cnt8)
`endif
  );

  avg_threshold_detector #(.WIDTH(8), .PERSIST(3), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample(sample),
    .sample_valid(sample_valid), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .clear(clear), .above(above2), .rise_pulse(rise2), .fall_pulse(fall2),
`ifdef AVG_DET_PEAK_HOLD_EN
    .event_count(cnt2), .peak(peak2)
`else
    .event_count(cnt2)
`endif
  );

  typedef struct {
    logic       ena;
    logic       valid;
    logic [7:0] smp;
    logic       clr;
    logic       exp_above;
    logic       exp_rise;
    logic       exp_fall;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic ea, input logic er,
                            input logic ef);
    chk({tag, " above"}, int'(above8), int'(ea));
    chk({tag, " rise"},  int'(rise8),  int'(er));
    chk({tag, " fall"},  int'(fall8),  int'(ef));
    chk({tag, " cnt8"},  int'(cnt8),   e8);
    chk({tag, " above2"}, int'(above2), int'(ea));
    chk({tag, " rise2"},  int'(rise2),  int'(er));
    chk({tag, " cnt2"},  int'(cnt2),   e2);
  endtask

  // One accepted sample, then check the registered outputs one edge later.
  task automatic step(input logic [7:0] s, input logic clr, input logic ea,
                      input logic er, input logic ef, input string tag);
    ena = 1'b1; sample_valid = 1'b1; sample = s; clear = clr;
    @(posedge clk); #1;
    sample_valid = 1'b0; clear = 1'b0;
    $display("[TB] %s sample=%0d clr=%0d above=%0d rise=%0d fall=%0d cnt8=%0d cnt2=%0d",
             tag, s, clr, above8, rise8, fall8, cnt8, cnt2);
    check_both(tag, ea, er, ef);
  endtask

  task automatic bump_rise();
    e8 = (e8 < 255) ? e8 + 1 : 255;
    e2 = (e2 < 3) ? e2 + 1 : 3;
  endtask

  task automatic add(input logic en, input logic v, input logic [7:0] s,
                     input logic a, input logic r, input logic f, input int c);
    vec_t t;
    t = '{ena: en, valid: v, smp: s, clr: 1'b0, exp_above: a, exp_rise: r,
          exp_fall: f, exp_cnt: c};
    vecs.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; sample = '0; sample_valid = 1'b0;
    thr_hi = 8'd100; thr_lo = 8'd50; clear = 1'b0;

    // Broken persistence, then a clean rise.
    add(1, 1, 120, 0, 0, 0, 0);
    add(1, 1, 130, 0, 0, 0, 0);
    add(1, 1,  90, 0, 0, 0, 0);
    add(1, 1, 120, 0, 0, 0, 0);
    add(1, 1, 130, 0, 0, 0, 0);
    add(1, 1, 140, 1, 1, 0, 1);
    add(1, 0,   0, 1, 0, 0, 1);
    // Hysteresis band, then a committed fall.
    add(1, 1,  70, 1, 0, 0, 1);
    add(1, 1,  60, 1, 0, 0, 1);
    add(1, 1,  55, 1, 0, 0, 1);
    add(1, 1,  50, 1, 0, 0, 1);
    add(1, 1,  40, 1, 0, 0, 1);
    add(1, 1,  30, 0, 0, 1, 1);
    add(1, 0,   0, 0, 0, 0, 1);
    // Gated samples are ignored.
    add(0, 1, 200, 0, 0, 0, 1);
    add(0, 1, 200, 0, 0, 0, 1);
    add(0, 1, 200, 0, 0, 0, 1);
    // Two qualifying samples leave the detector in PEND_UP with cnt=2.
    add(1, 1, 200, 0, 0, 0, 1);
    add(1, 1, 200, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    check_both("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      ena = vecs[i].ena; sample_valid = vecs[i].valid;
      sample = vecs[i].smp; clear = vecs[i].clr;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      e8 = vecs[i].exp_cnt;
      e2 = (vecs[i].exp_cnt > 3) ? 3 : vecs[i].exp_cnt;
      $display("[TB] vec%0d ena=%0d valid=%0d sample=%0d above=%0d rise=%0d fall=%0d cnt=%0d",
               i, vecs[i].ena, vecs[i].valid, vecs[i].smp, above8, rise8, fall8, cnt8);
      check_both($sformatf("vec%0d", i), vecs[i].exp_above, vecs[i].exp_rise,
                 vecs[i].exp_fall);
    end

    // Asynchronous reset mid-pending: outputs clear without waiting for an edge.
    #3 rst_n = 1'b0;
    #1;
    e8 = 0; e2 = 0;
    $display("[TB] async reset above=%0d cnt8=%0d", above8, cnt8);
    check_both("async_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Pending count restarted at zero: three more samples are needed.
    step(200, 0, 0, 0, 0, "post_rst1");
    step(200, 0, 0, 0, 0, "post_rst2");
    bump_rise();
    step(200, 0, 1, 1, 0, "post_rst3");

    // Repeated rise/fall cycles drive the 2-bit counter into saturation.
    for (int k = 0; k < 4; k++) begin
      step(10, 0, 1, 0, 0, $sformatf("cyc%0d_dn1", k));
      step(10, 0, 1, 0, 0, $sformatf("cyc%0d_dn2", k));
      step(10, 0, 0, 0, 1, $sformatf("cyc%0d_dn3", k));
      step(200, 0, 0, 0, 0, $sformatf("cyc%0d_up1", k));
      step(200, 0, 0, 0, 0, $sformatf("cyc%0d_up2", k));
      bump_rise();
      step(200, 0, 1, 1, 0, $sformatf("cyc%0d_up3", k));
    end
    chk("sat cnt2", int'(cnt2), 3);
    chk("sat cnt8", int'(cnt8), 5);

    // Clear coincident with the sixth rise commit yields a count of one.
    step(10, 0, 1, 0, 0, "six_dn1");
    step(10, 0, 1, 0, 0, "six_dn2");
    step(10, 0, 0, 0, 1, "six_dn3");
    step(200, 0, 0, 0, 0, "six_up1");
    step(200, 0, 0, 0, 0, "six_up2");
    e8 = 1; e2 = 1;
    step(200, 1, 1, 1, 0, "six_up3_clr");

    // Clear alone zeroes the count but leaves the level state untouched.
    ena = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    e8 = 0; e2 = 0;
    $display("[TB] clear_only above=%0d cnt8=%0d", above8, cnt8);
    check_both("clear_only", 1'b1, 1'b0, 1'b0);
    step(10, 0, 1, 0, 0, "after_clr1");

`ifdef AVG_DET_PEAK_HOLD_EN
    step(200, 0, 1, 0, 0, "peak_reset_pend");
    step(10,  0, 1, 0, 0, "peak_s10");
    step(200, 0, 1, 0, 0, "peak_s200");
    step(150, 0, 1, 0, 0, "peak_s150");
    chk("peak max", int'(peak8), 200);
    step(30, 1, 1, 0, 0, "peak_clr30");
    chk("peak clear", int'(peak8), 30);
    chk("peak2 clear", int'(peak2), 30);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
